// File: rtl/bp_io_cmd_mux_n.sv
// N-source BedRock IO command mux with in-order source-tag FIFO for response return.
// Define BP_IO_MUX_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module bp_io_cmd_mux_n #(
    parameter int num_src_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_src_p*msg_width_p-1:0]       src_cmd_i,
    input  logic [num_src_p-1:0]                   src_cmd_v_i,
    output logic [num_src_p-1:0]                   src_cmd_ready_and_o,
    output logic [msg_width_p-1:0]                 src_resp_o,
    output logic [num_src_p-1:0]                   src_resp_v_o,
    input  logic [num_src_p-1:0]                   src_resp_ready_and_i,
    output logic [msg_width_p-1:0]                 io_cmd_o,
    output logic                                   io_cmd_v_o,
    input  logic                                   io_cmd_ready_and_i,
    input  logic [msg_width_p-1:0]                 io_resp_i,
    input  logic                                   io_resp_v_i,
    output logic                                   io_resp_ready_and_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

    localparam int id_w_lp  = $clog2(num_src_p);
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p+1);

    logic [msg_width_p-1:0] cmd_q;
    logic                   cmd_v_q;
    logic [id_w_lp-1:0]     tag_q [max_outstanding_p];
    logic [ptr_w_lp-1:0]    wptr_q;
    logic [ptr_w_lp-1:0]    rptr_q;
    logic [cnt_w_lp-1:0]    cnt_q;
    logic [cnt_w_lp-1:0]    cnt_d;

    logic                   free;
    logic                   full;
    logic                   empty;
    logic                   grant_v;
    logic [id_w_lp-1:0]     grant_id;
    logic                   push;
    logic                   pop;
    logic [id_w_lp-1:0]     head;
    logic [msg_width_p-1:0] cmd_sel;
    logic [id_w_lp-1:0]     base;

`ifdef BP_IO_MUX_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [id_w_lp-1:0] rr_q;
    logic [id_w_lp-1:0] rr_d;

    assign base = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            if (grant_id == id_w_lp'(num_src_p-1)) rr_d = '0;
            else                                    rr_d = grant_id + id_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) rr_q <= '0;
        else          rr_q <= rr_d;
    end
`endif

    assign free  = !cmd_v_q || io_cmd_ready_and_i;
    assign full  = (cnt_q == cnt_w_lp'(max_outstanding_p));
    assign empty = (cnt_q == '0);
    assign push  = reset_i && free && !full && grant_v;

    // Search upward from base, wrapping modulo num_src_p.
    always_comb begin
        int                 idx_int;
        logic [id_w_lp-1:0] idx;
        grant_v  = 1'b0;
        grant_id = '0;
        idx_int  = 0;
        idx      = '0;
        for (int i = 0; i < num_src_p; i++) begin
            idx_int = int'(base) + i;
            if (idx_int >= num_src_p) idx_int = idx_int - num_src_p;
            idx = id_w_lp'(idx_int);
            if (!grant_v && src_cmd_v_i[idx]) begin
                grant_v  = 1'b1;
                grant_id = idx;
            end
        end
    end

    always_comb begin
        src_cmd_ready_and_o = '0;
        cmd_sel             = '0;
        for (int s = 0; s < num_src_p; s++) begin
            if (grant_id == id_w_lp'(s)) begin
                src_cmd_ready_and_o[s] = push;
                cmd_sel                = src_cmd_i[s*msg_width_p +: msg_width_p];
            end
        end
    end

    assign head = tag_q[rptr_q];

    // Responses follow command order; an empty FIFO stalls stray responses.
    always_comb begin
        src_resp_v_o        = '0;
        io_resp_ready_and_o = 1'b0;
        for (int s = 0; s < num_src_p; s++) begin
            if (!empty && head == id_w_lp'(s)) begin
                src_resp_v_o[s]     = io_resp_v_i;
                io_resp_ready_and_o = src_resp_ready_and_i[s];
            end
        end
    end

    assign pop = io_resp_v_i && io_resp_ready_and_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
        end else if (push) begin
            cmd_q   <= cmd_sel;
            cmd_v_q <= 1'b1;
        end else if (io_cmd_ready_and_i) begin
            cmd_v_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int e = 0; e < max_outstanding_p; e++) tag_q[e] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                tag_q[wptr_q] <= grant_id;
                wptr_q        <= wptr_q + ptr_w_lp'(1);
            end
            if (pop) rptr_q <= rptr_q + ptr_w_lp'(1);
        end
    end

    assign io_cmd_o      = cmd_q;
    assign io_cmd_v_o    = cmd_v_q;
    assign src_resp_o    = io_resp_i;
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_bp_io_cmd_mux_n.sv
// Directed bench for bp_io_cmd_mux_n: 3 sources, 16-bit messages, 4 outstanding.
module tb_bp_io_cmd_mux_n;

    localparam int N = 3;
    localparam int W = 16;
    localparam int M = 4;

    logic           clk;
    logic           reset_i;
    logic [N*W-1:0] src_cmd_i;
    logic [N-1:0]   src_cmd_v_i;
    logic [N-1:0]   src_cmd_ready_and_o;
    logic [W-1:0]   src_resp_o;
    logic [N-1:0]   src_resp_v_o;
    logic [N-1:0]   src_resp_ready_and_i;
    logic [W-1:0]   io_cmd_o;
    logic           io_cmd_v_o;
    logic           io_cmd_ready_and_i;
    logic [W-1:0]   io_resp_i;
    logic           io_resp_v_i;
    logic           io_resp_ready_and_o;
    logic [2:0]     outstanding_o;

    int checks = 0;
    int errors = 0;

    bp_io_cmd_mux_n #(
        .num_src_p(N),
        .msg_width_p(W),
        .max_outstanding_p(M)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .src_cmd_i(src_cmd_i),
        .src_cmd_v_i(src_cmd_v_i),
        .src_cmd_ready_and_o(src_cmd_ready_and_o),
        .src_resp_o(src_resp_o),
        .src_resp_v_o(src_resp_v_o),
        .src_resp_ready_and_i(src_resp_ready_and_i),
        .io_cmd_o(io_cmd_o),
        .io_cmd_v_o(io_cmd_v_o),
        .io_cmd_ready_and_i(io_cmd_ready_and_i),
        .io_resp_i(io_resp_i),
        .io_resp_v_i(io_resp_v_i),
        .io_resp_ready_and_o(io_resp_ready_and_o),
        .outstanding_o(outstanding_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_cmd_i            = {16'hC002, 16'hC001, 16'hC000};
        src_cmd_v_i          = '0;
        src_resp_ready_and_i = '0;
        io_cmd_ready_and_i   = 1'b1;
        io_resp_i            = '0;
        io_resp_v_i          = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        src_cmd_v_i          = 3'b111;
        src_resp_ready_and_i = 3'b111;
        io_resp_v_i          = 1'b1;
        reset_i              = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({io_cmd_v_o, io_resp_ready_and_o, src_resp_v_o,
                 src_cmd_ready_and_o, outstanding_o} !== 11'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got cv=%b rr=%b rv=%b cr=%b out=%0d want all 0",
                         c, io_cmd_v_o, io_resp_ready_and_o, src_resp_v_o,
                         src_cmd_ready_and_o, outstanding_o);
            end
        end
        io_resp_v_i = 1'b0;
        reset_i     = 1'b1;
        #1;
        checks++;
        if (src_cmd_ready_and_o !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant got %b want 001", src_cmd_ready_and_o);
        end
        step();
        src_cmd_v_i = '0;
    endtask

    task automatic test_round_robin();
        int         exp_g [5];
        logic [2:0] e;
        logic [2:0] h;
`ifdef BP_IO_MUX_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 0, 1};
`endif
        apply_reset();
        src_cmd_v_i          = 3'b111;
        src_resp_ready_and_i = 3'b111;
        io_resp_v_i          = 1'b1;
        io_resp_i            = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            #1;
            e = 3'b001 << exp_g[k];
            checks++;
            if (src_cmd_ready_and_o !== e) begin
                errors++;
                $display("FAIL rr_grant k=%0d got %b want %b", k, src_cmd_ready_and_o, e);
            end
            if (k == 0) begin
                checks++;
                if (io_cmd_v_o !== 1'b0 || src_resp_v_o !== 3'b000 || outstanding_o !== 3'd0) begin
                    errors++;
                    $display("FAIL rr_first got cv=%b rv=%b out=%0d want 0 000 0",
                             io_cmd_v_o, src_resp_v_o, outstanding_o);
                end
            end else begin
                h = 3'b001 << exp_g[k-1];
                checks++;
                if (io_cmd_v_o !== 1'b1 || io_cmd_o !== (16'hC000 + 16'(exp_g[k-1]))) begin
                    errors++;
                    $display("FAIL rr_io_cmd k=%0d got v=%b d=%h want 1 %h", k, io_cmd_v_o,
                             io_cmd_o, 16'hC000 + 16'(exp_g[k-1]));
                end
                checks++;
                if (src_resp_v_o !== h || outstanding_o !== 3'd1 || src_resp_o !== 16'h5555) begin
                    errors++;
                    $display("FAIL rr_resp k=%0d got rv=%b out=%0d d=%h want %b 1 5555",
                             k, src_resp_v_o, outstanding_o, src_resp_o, h);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        logic [2:0] e;
`ifdef BP_IO_MUX_FIXED_PRIO_EN
        e = 3'b001;
`else
        e = 3'b010;
`endif
        apply_reset();
        src_cmd_v_i = 3'b111;
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outstanding_o !== 3'd4 || src_cmd_ready_and_o !== 3'b000) begin
                errors++;
                $display("FAIL full_block k=%0d got out=%0d cr=%b want 4 000",
                         k, outstanding_o, src_cmd_ready_and_o);
            end
            step();
        end
        io_resp_v_i          = 1'b1;
        src_resp_ready_and_i = 3'b111;
        io_resp_i            = 16'h0077;
        #1;
        checks++;
        if (io_resp_ready_and_o !== 1'b1 || src_resp_v_o !== 3'b001 || src_cmd_ready_and_o !== 3'b000) begin
            errors++;
            $display("FAIL full_pop got rr=%b rv=%b cr=%b want 1 001 000",
                     io_resp_ready_and_o, src_resp_v_o, src_cmd_ready_and_o);
        end
        step();
        io_resp_v_i = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd3 || src_cmd_ready_and_o !== e) begin
            errors++;
            $display("FAIL full_regrant got out=%0d cr=%b want 3 %b",
                     outstanding_o, src_cmd_ready_and_o, e);
        end
        step();
        checks++;
        if (outstanding_o !== 3'd4 || src_cmd_ready_and_o !== 3'b000) begin
            errors++;
            $display("FAIL full_again got out=%0d cr=%b want 4 000",
                     outstanding_o, src_cmd_ready_and_o);
        end
        idle_inputs();
    endtask

    task automatic test_routing();
        logic [2:0]  srcs [3];
        logic [15:0] pay  [3];
        srcs = '{3'b100, 3'b001, 3'b010};
        pay  = '{16'h000A, 16'h000B, 16'h000C};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            src_cmd_v_i = srcs[k];
            #1;
            checks++;
            if (src_cmd_ready_and_o !== srcs[k]) begin
                errors++;
                $display("FAIL route_grant k=%0d got %b want %b", k, src_cmd_ready_and_o, srcs[k]);
            end
            step();
        end
        src_cmd_v_i          = '0;
        src_resp_ready_and_i = 3'b111;
        io_resp_v_i          = 1'b1;
        for (int k = 0; k < 3; k++) begin
            io_resp_i = pay[k];
            #1;
            checks++;
            if (src_resp_v_o !== srcs[k] || src_resp_o !== pay[k] || io_resp_ready_and_o !== 1'b1) begin
                errors++;
                $display("FAIL route_resp k=%0d got rv=%b d=%h rr=%b want %b %h 1",
                         k, src_resp_v_o, src_resp_o, io_resp_ready_and_o, srcs[k], pay[k]);
            end
            step();
        end
        checks++;
        if (outstanding_o !== 3'd0 || io_resp_ready_and_o !== 1'b0 || src_resp_v_o !== 3'b000) begin
            errors++;
            $display("FAIL route_drained got out=%0d rr=%b rv=%b want 0 0 000",
                     outstanding_o, io_resp_ready_and_o, src_resp_v_o);
        end
        idle_inputs();
    endtask

    task automatic test_resp_stall();
        apply_reset();
        src_cmd_v_i = 3'b010;
        step();
        src_cmd_v_i          = '0;
        io_resp_v_i          = 1'b1;
        io_resp_i            = 16'h00EE;
        src_resp_ready_and_i = 3'b101;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (io_resp_ready_and_o !== 1'b0 || outstanding_o !== 3'd1 || src_resp_v_o !== 3'b010) begin
                errors++;
                $display("FAIL stall c=%0d got rr=%b out=%0d rv=%b want 0 1 010",
                         c, io_resp_ready_and_o, outstanding_o, src_resp_v_o);
            end
            step();
        end
        src_resp_ready_and_i = 3'b111;
        #1;
        checks++;
        if (io_resp_ready_and_o !== 1'b1 || src_resp_v_o !== 3'b010) begin
            errors++;
            $display("FAIL stall_release got rr=%b rv=%b want 1 010", io_resp_ready_and_o, src_resp_v_o);
        end
        step();
        io_resp_v_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL stall_pop got out=%0d want 0", outstanding_o);
        end
        idle_inputs();
    endtask

    task automatic test_midflight_reset();
        apply_reset();
        src_cmd_v_i = 3'b111;
        for (int k = 0; k < 3; k++) step();
        src_cmd_v_i        = '0;
        io_cmd_ready_and_i = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd3 || io_cmd_v_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got out=%0d cv=%b want 3 1", outstanding_o, io_cmd_v_o);
        end
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        #1;
        checks++;
        if (outstanding_o !== 3'd0 || io_cmd_v_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_cleared got out=%0d cv=%b want 0 0", outstanding_o, io_cmd_v_o);
        end
        io_resp_v_i          = 1'b1;
        src_resp_ready_and_i = 3'b111;
        #1;
        checks++;
        if (io_resp_ready_and_o !== 1'b0 || src_resp_v_o !== 3'b000) begin
            errors++;
            $display("FAIL mid_stray got rr=%b rv=%b want 0 000", io_resp_ready_and_o, src_resp_v_o);
        end
        step();
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL mid_stray_count got out=%0d want 0", outstanding_o);
        end
        idle_inputs();
    endtask

    initial begin
        reset_i = 1'b0;
        idle_inputs();
        step();
        test_reset();
        test_round_robin();
        test_full();
        test_routing();
        test_resp_stall();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
